hilo_unit: RTL and testbench

Iterative multiply/divide sequencer that owns the HI and LO registers feeding write-back select inputs 2 (`hiOut`) and 3 (`loOut`). The main control FSM issues an operation with a one-cycle `start`, stalls on `busy`, and then selects HI or LO on the write-back mux once `done` pulses. The block also executes MTHI/MTLO writes directly.

---
 rtl/hilo_pkg.sv | 23 ++
 rtl/hilo_iter_step.sv | 44 ++++
 rtl/hilo_unit.sv | 190 +++++++++++++++++++
 tb/tb_hilo_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// hilo_pkg: shared types and constants for the HI/LO multiply/divide unit.
//   hilo_op_t    : operation encoding on the `op` port.
//   hilo_state_t : sequencer states.
//   HILO_ITER    : default operand width and number of CALC iterations.
package hilo_pkg;

  localparam int unsigned HILO_ITER = 32;

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_MTHI = 2'b10,
    OP_MTLO = 2'b11
  } hilo_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } hilo_state_t;

endpackage

// File: rtl/hilo_iter_step.sv
// hilo_iter_step: one combinational iteration of the unsigned multiply or
// restoring divide performed on operand magnitudes.
//   mode_div : 0 = shift-add multiply step, 1 = shift-subtract divide step.
//   acc_in   : 2*WIDTH accumulator. Multiply: partial product.
//              Divide: {remainder, quotient-so-far}.
//   operand  : multiplicand (multiply) or divisor (divide).
//   bit_in   : next multiplier bit (multiply) or next dividend bit (divide),
//              both taken MSB first.
//   acc_out  : accumulator after this iteration.
module hilo_iter_step
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = HILO_ITER
) (
  input  logic                 mode_div,
  input  logic [2*WIDTH-1:0]   acc_in,
  input  logic [WIDTH-1:0]     operand,
  input  logic                 bit_in,
  output logic [2*WIDTH-1:0]   acc_out
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             q_bit;

  always_comb begin
    addend = bit_in ? operand : '0;
    // Partial remainder shifted left with the next dividend bit brought in.
    // It is always below 2*divisor, so WIDTH+1 bits hold it and the top bit
    // of the difference is a clean borrow flag.
    trial  = {acc_in[2*WIDTH-1:WIDTH], bit_in};
    diff   = trial - {1'b0, operand};
    q_bit  = ~diff[WIDTH];
    if (mode_div) begin
      acc_out = {(q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0]),
                 acc_in[WIDTH-2:0], q_bit};
    end else begin
      // MSB-first: double the partial product, then add in this bit's term.
      acc_out = {acc_in[2*WIDTH-2:0], 1'b0} + {{WIDTH{1'b0}}, addend};
    end
  end

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: iterative signed multiply/divide sequencer owning HI and LO.
//   clk, reset : clock (rising edge) and asynchronous active-high reset.
//   start, op  : one-cycle request; op 00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
//   a, b       : rs / rt operands (a = dividend or MTHI/MTLO data, b = divisor).
//   busy, done : operation in flight / one-cycle completion pulse.
//   divZero    : pulses with done on DIV by zero (HILO_DIV_ZERO_TRAP_EN only,
//                otherwise tied to 0).
//   hiOut/loOut: HI and LO registers.
// Optional feature macro: HILO_DIV_ZERO_TRAP_EN. When defined, DIV by zero
// leaves HI/LO untouched and raises divZero; otherwise the natural restoring
// result is written.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = HILO_ITER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             divZero,
  output logic [WIDTH-1:0] hiOut,
  output logic [WIDTH-1:0] loOut
);

  localparam int unsigned   CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  hilo_state_t        state_q, state_d;
  logic               is_div_q, is_div_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [WIDTH-1:0]   mag_a_q, mag_a_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  hilo_op_t           op_e;
  logic               step_bit;
  logic [WIDTH-1:0]   step_operand;
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;

  always_comb begin
    step_bit     = is_div_q ? mag_a_q[cnt_q] : mag_b_q[cnt_q];
    step_operand = is_div_q ? mag_b_q : mag_a_q;
  end

  hilo_iter_step #(.WIDTH(WIDTH)) u_step (
    .mode_div (is_div_q),
    .acc_in   (acc_q),
    .operand  (step_operand),
    .bit_in   (step_bit),
    .acc_out  (step_acc)
  );

  // Sign fixup of the unsigned magnitude results. The quotient is negative
  // when operand signs differ; the remainder follows the dividend.
  always_comb begin
    prod_s = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quo_s  = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_s  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    op_e     = hilo_op_t'(op);
    state_d  = state_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;

    case (state_q)
      // DONE behaves like IDLE for new requests so back-to-back issue
      // costs no bubble cycle.
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          case (op_e)
            OP_MULT, OP_DIV: begin
              state_d  = ST_CALC;
              is_div_d = (op_e == OP_DIV);
              sign_a_d = a[WIDTH-1];
              sign_b_d = b[WIDTH-1];
              mag_a_d  = a[WIDTH-1] ? -a : a;
              mag_b_d  = b[WIDTH-1] ? -b : b;
              acc_d    = '0;
              cnt_d    = CNT_LAST;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      ST_CALC: begin
        acc_d = step_acc;
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_FIX: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod_s[2*WIDTH-1:WIDTH];
          lo_d = prod_s[WIDTH-1:0];
        end else begin
`ifdef HILO_DIV_ZERO_TRAP_EN
          if (mag_b_q == '0) begin
            dz_d = 1'b1;
          end else begin
            hi_d = rem_s;
            lo_d = quo_s;
          end
`else
          hi_d = rem_s;
          lo_d = quo_s;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign hiOut = hi_q;
  assign loOut = lo_q;
`ifdef HILO_DIV_ZERO_TRAP_EN
  assign divZero = dz_q;
`else
  assign divZero = 1'b0;
`endif

endmodule

// File: tb/tb_hilo_unit.sv
module tb_hilo_unit;
  import hilo_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         divZero;
  logic [W-1:0] hiOut;
  logic [W-1:0] loOut;

  hilo_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .divZero (divZero),
    .hiOut   (hiOut),
    .loOut   (loOut)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           due;
    string        name;
  } exp_t;

  exp_t sb[$];
  logic [W-1:0] last_hi;
  logic [W-1:0] last_lo;

  typedef struct {
    logic [1:0]   o;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vt [8] = '{
    '{OP_DIV,  32'hFFFFFFEF, 32'h00000005, 32'hFFFFFFFE, 32'hFFFFFFFD},
    '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
    '{OP_DIV,  32'd100,      32'd7,        32'd2,        32'd14},
    '{OP_DIV,  32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD},
    '{OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001},
    '{OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
    '{OP_MULT, 32'h40000000, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'h00000000},
    '{OP_MULT, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000}
  };

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drives one request across exactly one rising edge; returns #1 into the
  // following cycle. MULT/DIV push their expected result and completion cycle.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                       input string name);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    if (o == OP_MULT || o == OP_DIV) begin
      sb.push_back('{hi: ehi, lo: elo, dz: edz, due: cyc + 34, name: name});
      last_hi = ehi;
      last_lo = elo;
    end else if (o == OP_MTHI) begin
      last_hi = av;
    end else begin
      last_lo = av;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_idle actual=busy expected=idle_within_200", name);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=done expected=no_pending_op cyc=%0d", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_hi"},  hiOut,       e.hi);
        chk({e.name, "_lo"},  loOut,       e.lo);
        chk({e.name, "_dz"},  W'(divZero), W'(e.dz));
        chk({e.name, "_lat"}, W'(cyc),     W'(e.due));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int           busy_cnt;
    logic         busy_c35;
    logic [W-1:0] lo_fix;

    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    last_hi = '0; last_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi",   hiOut,       '0);
    chk("rst_lo",   loOut,       '0);
    chk("rst_busy", W'(busy),    '0);
    chk("rst_done", W'(done),    '0);
    chk("rst_dz",   W'(divZero), '0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // MULT 7 * -3 with busy profile and HI/LO hold during the run.
    issue(OP_MULT, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mul_7_m3");
    busy_cnt = 0; busy_c35 = 1'b1; lo_fix = 'x;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (k <= 34 && busy) busy_cnt++;
      if (k == 33) lo_fix = loOut;
      if (k == 35) busy_c35 = busy;
    end
    chk("mul_busy_cycles", W'(busy_cnt), 32'd34);
    chk("mul_busy_c35",    W'(busy_c35), '0);
    chk("mul_lo_hold_fix", lo_fix,       '0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      issue(vt[i].o, vt[i].av, vt[i].bv, vt[i].hi, vt[i].lo, 1'b0, $sformatf("vec%0d", i));
      wait_idle($sformatf("vec%0d", i));
    end

    // MTHI then MTLO on consecutive edges.
    issue(OP_MTHI, 32'h12345678, '0, '0, '0, 1'b0, "mthi");
    chk("mthi_hi",   hiOut,    32'h12345678);
    chk("mthi_busy", W'(busy), '0);
    issue(OP_MTLO, 32'h9ABCDEF0, '0, '0, '0, 1'b0, "mtlo");
    chk("mtlo_lo",      loOut,    32'h9ABCDEF0);
    chk("mtlo_hi_keep", hiOut,    32'h12345678);
    chk("mtlo_busy",    W'(busy), '0);
    chk("mtlo_done",    W'(done), '0);
    @(posedge clk);
    #1;

    // DIV -100 / 7 with stray MULT requests in cycles 5 and 20.
    issue(OP_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0, "div_ign");
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    start = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle("div_ign");

    // Back-to-back: second MULT issued in the DONE cycle of the first.
    issue(OP_MULT, 32'd6, 32'd7, '0, 32'd42, 1'b0, "b2b_a");
    repeat (33) @(posedge clk);
    #1;
    issue(OP_MULT, 32'hFFFFFFFB, 32'hFFFFFFFA, '0, 32'd30, 1'b0, "b2b_b");
    wait_idle("b2b");

    // Division by zero.
`ifdef HILO_DIV_ZERO_TRAP_EN
    issue(OP_DIV, 32'd9, '0, last_hi, last_lo, 1'b1, "divz_pos");
    wait_idle("divz_pos");
    issue(OP_DIV, 32'hFFFFFFF7, '0, last_hi, last_lo, 1'b1, "divz_neg");
    wait_idle("divz_neg");
`else
    issue(OP_DIV, 32'd9, '0, 32'd9, 32'hFFFFFFFF, 1'b0, "divz_pos");
    wait_idle("divz_pos");
    issue(OP_DIV, 32'hFFFFFFF7, '0, 32'hFFFFFFF7, 32'h00000001, 1'b0, "divz_neg");
    wait_idle("divz_neg");
`endif

    // Asynchronous reset in cycle 15 of a MULT.
    issue(OP_MULT, 32'd1000, 32'd1000, '0, 32'h000F4240, 1'b0, "mul_rst");
    repeat (14) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_hi",   hiOut,       '0);
    chk("arst_lo",   loOut,       '0);
    chk("arst_busy", W'(busy),    '0);
    chk("arst_done", W'(done),    '0);
    chk("arst_dz",   W'(divZero), '0);
    sb.delete();
    last_hi = '0;
    last_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    issue(OP_MULT, 32'd3, 32'd4, '0, 32'd12, 1'b0, "mul_3x4");
    wait_idle("mul_3x4");

    chk("sb_drained", W'(sb.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
